// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: redirect from EX, instruction-memory request/response, and the ID-side head.
// master = fetch queue, slave = the surrounding pipeline/memory.
interface instr_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    input  redirect_valid, redirect_pc, im_req_ready, im_rsp_valid, im_rsp_data, id_ready,
    output im_req_valid, im_req_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, im_req_ready, im_rsp_valid, im_rsp_data, id_ready,
    input  im_req_valid, im_req_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// IF-stage front end: sequential PC generation, credit-limited IM requests, in-order instruction
// queue toward ID, and flush/drop accounting for redirects from EX.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_queue_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_hold_addr;
  logic          r_started;
  logic          r_held;
  logic          r_stale;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_q_rd;
  logic [AW-1:0] r_q_wr;
  logic [AW-1:0] r_pf_rd;
  logic [AW-1:0] r_pf_wr;
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_pf      [DEPTH];

  logic [CW:0]   w_used;
  logic          w_credit;
  logic          w_req_valid;
  logic [31:0]   w_req_addr;
  logic          w_accept;
  logic          w_rsp_drop;
  logic          w_q_push;
  logic          w_q_pop;
  logic          w_pf_push;
  logic [CW-1:0] w_inflight_nxt;

  assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit    = (w_used < (CW+1)'(DEPTH));
  // A raised request stays up (old address) until accepted, even across a redirect.
  assign w_req_valid = r_held | (r_started & w_credit & ~bus.redirect_valid);
  assign w_req_addr  = r_held ? r_hold_addr : r_fetch_pc;
  assign w_accept    = w_req_valid & bus.im_req_ready;
  assign w_rsp_drop  = bus.im_rsp_valid & (r_drop_cnt != '0);
  assign w_q_push    = bus.im_rsp_valid & (r_drop_cnt == '0) & ~bus.redirect_valid;
  assign w_q_pop     = (r_count != '0) & bus.id_ready & ~bus.redirect_valid;
  assign w_pf_push   = w_accept & ~r_stale & ~bus.redirect_valid;
  assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(bus.im_rsp_valid);

  assign bus.im_req_valid = w_req_valid;
  assign bus.im_req_addr  = w_req_addr;
  assign bus.id_valid     = (r_count != '0);
  assign bus.id_instr     = r_q_instr[r_q_rd];
  assign bus.id_pc        = r_q_pc[r_q_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_hold_addr <= RESET_PC;
      r_started   <= 1'b0;
      r_held      <= 1'b0;
      r_stale     <= 1'b0;
      r_inflight  <= '0;
      r_drop_cnt  <= '0;
      r_count     <= '0;
      r_q_rd      <= '0;
      r_q_wr      <= '0;
      r_pf_rd     <= '0;
      r_pf_wr     <= '0;
    end else begin
      r_started   <= 1'b1;
      r_held      <= w_req_valid & ~bus.im_req_ready;
      r_hold_addr <= w_req_addr;
      r_inflight  <= w_inflight_nxt;
      if (bus.redirect_valid) begin
        // Everything accepted up to and including this cycle is owed but unwanted.
        r_fetch_pc <= bus.redirect_pc;
        r_stale    <= w_req_valid & ~bus.im_req_ready;
        r_drop_cnt <= w_inflight_nxt;
        r_count    <= '0;
        r_q_rd     <= '0;
        r_q_wr     <= '0;
        r_pf_rd    <= '0;
        r_pf_wr    <= '0;
      end else begin
        if (w_accept && !r_stale) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_accept) r_stale <= 1'b0;
        r_drop_cnt <= r_drop_cnt + CW'(w_accept & r_stale) - CW'(w_rsp_drop);
        r_count    <= r_count + CW'(w_q_push) - CW'(w_q_pop);
        if (w_q_push) begin
          r_q_wr  <= r_q_wr + 1'b1;
          r_pf_rd <= r_pf_rd + 1'b1;
        end
        if (w_q_pop)   r_q_rd  <= r_q_rd + 1'b1;
        if (w_pf_push) r_pf_wr <= r_pf_wr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pf_push) r_pf[r_pf_wr] <= w_req_addr;
    if (w_q_push) begin
      r_q_instr[r_q_wr] <= bus.im_rsp_data;
      r_q_pc[r_q_wr]    <= r_pf[r_pf_rd];
    end
  end

  a_q_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_q_push && !w_q_pop && (r_count == CW'(DEPTH))));

endmodule
